frame_config_loader: RTL

//  Configuration front-end that drives the fabric's FrameData rows and FrameStrobe columns.
//  - Accepts 32-bit configuration words on a valid/ready stream.
//  - Assembles one frame per header: one header word followed by NumRows data words.
//  - Writes the frame into a column by pulsing exactly one FrameStrobe bit.
//  - Its outputs feed the FrameData/FrameStrobe inputs of the edge and terminal tiles, which buffer and daisy-chain them.

---
 rtl/frame_config_loader_pkg.sv | 25 ++
 rtl/frame_config_loader_strobe_decoder.sv | 37 +++
 rtl/frame_config_loader.sv | 118 +++++++++++
 3 files changed

// File: rtl/frame_config_loader_pkg.sv
// Shared definitions for the frame configuration loader: header layout,
// sync marker and FSM state type.
package frame_config_loader_pkg;

  localparam logic [7:0]  FRAME_SYNC   = 8'hA5;

  // Header field positions (each field is 8 bits wide)
  localparam int unsigned HDR_SYNC_LSB = 24;
  localparam int unsigned HDR_COL_LSB  = 16;
  localparam int unsigned HDR_FRM_LSB  = 8;
  localparam int unsigned HDR_FLD_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_STROBE = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  // Extract one 8-bit header field starting at bit lsb
  function automatic logic [7:0] hdr_field(input logic [31:0] w, input int unsigned lsb);
    return w[lsb +: HDR_FLD_W];
  endfunction

endpackage

// File: rtl/frame_config_loader_strobe_decoder.sv
// Registered one-hot decode of (column, frame, fire) into the FrameStrobe vector.
// At most one bit is high, and only in the cycle after fire is sampled.
module frame_strobe_decoder #(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned NumCols         = 16
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic [7:0]                           i_column,
  input  logic [7:0]                           i_frame,
  input  logic                                 i_fire,
  output logic [MaxFramesPerCol*NumCols-1:0]   o_strobe
);
  import frame_config_loader_pkg::*;

  localparam int unsigned NBits = MaxFramesPerCol * NumCols;
  localparam int unsigned IW    = $clog2(NBits);

  logic [IW-1:0]    w_idx;
  logic [NBits-1:0] r_strobe;

  assign w_idx = IW'(i_column) * IW'(MaxFramesPerCol) + IW'(i_frame);

  // One-hot strobe register, cleared every cycle fire is low
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_strobe <= '0;
    end else begin
      for (int unsigned i = 0; i < NBits; i++) begin
        r_strobe[i] <= i_fire && (w_idx == IW'(i));
      end
    end
  end

  assign o_strobe = r_strobe;

endmodule

// File: rtl/frame_config_loader.sv
// Configuration front-end: accepts header + NumRows data words on a
// valid/ready stream, loads row registers, then pulses one FrameStrobe bit.
module frame_config_loader #(
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned NumRows         = 16,
  parameter int unsigned NumCols         = 16
) (
  input  logic                                  CLK,
  input  logic                                  reset,
  input  logic [FrameBitsPerRow-1:0]            s_data,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  output logic [FrameBitsPerRow*NumRows-1:0]    FrameData,
  output logic [MaxFramesPerCol*NumCols-1:0]    FrameStrobe,
  output logic                                  busy,
  output logic                                  hdr_error,
  output logic [15:0]                           frames_done
);
  import frame_config_loader_pkg::*;

  localparam int unsigned RW = $clog2(NumRows);

  state_t                                     r_state;
  logic                                       r_ready;
  logic                                       r_busy;
  logic                                       r_hdr_error;
  logic [15:0]                                r_frames_done;
  logic [RW-1:0]                              r_row;
  logic [7:0]                                 r_col;
  logic [7:0]                                 r_frame;
  logic [NumRows-1:0][FrameBitsPerRow-1:0]    r_rows;

  logic                                       w_xfer;
  logic                                       w_hdr_ok;
  logic                                       w_last;
  logic                                       w_fire;

  assign w_xfer   = s_valid && r_ready;
  assign w_hdr_ok = (hdr_field(s_data, HDR_SYNC_LSB) == FRAME_SYNC)
                 && (hdr_field(s_data, HDR_COL_LSB) < 8'(NumCols))
                 && (hdr_field(s_data, HDR_FRM_LSB) < 8'(MaxFramesPerCol));
  assign w_last   = (r_row == RW'(NumRows - 1));
  // Fire on the transfer of the last data word so the registered strobe
  // appears in the same cycle the FSM sits in STROBE.
  assign w_fire   = (r_state == ST_DATA) && w_xfer && w_last;

  // Frame FSM with registered ready/busy decodes, row loading and counters
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_ready       <= 1'b0;
      r_busy        <= 1'b0;
      r_hdr_error   <= 1'b0;
      r_frames_done <= '0;
      r_row         <= '0;
      r_col         <= '0;
      r_frame       <= '0;
      r_rows        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (w_xfer) begin
            if (w_hdr_ok) begin
              r_col   <= hdr_field(s_data, HDR_COL_LSB);
              r_frame <= hdr_field(s_data, HDR_FRM_LSB);
              r_row   <= '0;
              r_busy  <= 1'b1;
              r_state <= ST_DATA;
            end else begin
              r_hdr_error <= 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (w_xfer) begin
            r_rows[r_row] <= s_data;
            r_row         <= r_row + 1'b1;
            if (w_last) begin
              r_frames_done <= r_frames_done + 16'd1;
              r_ready       <= 1'b0;
              r_state       <= ST_STROBE;
            end
          end
        end
        ST_STROBE: begin
          r_state <= ST_GAP;
        end
        ST_GAP: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  frame_strobe_decoder #(
    .MaxFramesPerCol (MaxFramesPerCol),
    .NumCols         (NumCols)
  ) u_strobe (
    .i_clk    (CLK),
    .i_rst    (reset),
    .i_column (r_col),
    .i_frame  (r_frame),
    .i_fire   (w_fire),
    .o_strobe (FrameStrobe)
  );

  assign s_ready     = r_ready;
  assign busy        = r_busy;
  assign hdr_error   = r_hdr_error;
  assign frames_done = r_frames_done;
  assign FrameData   = r_rows;

endmodule
